// File: rtl/writeback_unit.sv
// Writeback stage: arbitrates load returns, a one-entry ALU skid buffer and new
// ALU results onto the single register-file write port; tracks load tags for hazards.
module writeback_unit #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 4,
  parameter int NUM_REGS   = 9,
  parameter int LQ_DEPTH   = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  aluValid,
  output logic                  aluReady,
  input  logic [ADDR_WIDTH-1:0] aluAddr,
  input  logic [DATA_WIDTH-1:0] aluData,
  input  logic                  loadIssue,
  input  logic [ADDR_WIDTH-1:0] loadAddr,
  input  logic                  memValid,
  input  logic [DATA_WIDTH-1:0] memData,
  input  logic [ADDR_WIDTH-1:0] checkAddr1,
  input  logic [ADDR_WIDTH-1:0] checkAddr2,
  output logic                  stall,
  output logic                  writeEnable,
  output logic [ADDR_WIDTH-1:0] writeAddr,
  output logic [DATA_WIDTH-1:0] writeData,
  output logic [1:0]            loadCount,
  output logic                  overflowErr,
  output logic                  underflowErr
);

  localparam logic [1:0]          FULL_CNT = 2'(LQ_DEPTH);
  localparam logic [ADDR_WIDTH:0] NREG     = (ADDR_WIDTH+1)'(NUM_REGS);

  logic [1:0][ADDR_WIDTH-1:0] tag_q, tag_d;
  logic                       head_q, head_d, tail_q, tail_d;
  logic [1:0]                 count_q, count_d;
  logic                       skid_vld_q, skid_vld_d;
  logic [ADDR_WIDTH-1:0]      skid_addr_q, skid_addr_d;
  logic [DATA_WIDTH-1:0]      skid_data_q, skid_data_d;
  logic                       we_q, we_d;
  logic [ADDR_WIDTH-1:0]      waddr_q, waddr_d;
  logic [DATA_WIDTH-1:0]      wdata_q, wdata_d;
  logic                       ovf_q, ovf_d, unf_q, unf_d;

  logic                  pop, push, full, alu_acc, sel_vld;
  logic [ADDR_WIDTH-1:0] sel_addr;
  logic [DATA_WIDTH-1:0] sel_data;
  logic [1:0]            tag_vld;
  logic                  hit1, hit2;

  always_comb begin
    tag_d       = tag_q;
    head_d      = head_q;
    tail_d      = tail_q;
    count_d     = count_q;
    skid_vld_d  = skid_vld_q;
    skid_addr_d = skid_addr_q;
    skid_data_d = skid_data_q;
    waddr_d     = waddr_q;
    wdata_d     = wdata_q;
    sel_vld     = 1'b0;
    sel_addr    = '0;
    sel_data    = '0;

    full    = (count_q == FULL_CNT);
    pop     = memValid && (count_q != 2'd0);
    push    = loadIssue && (!full || pop);
    alu_acc = aluValid && !skid_vld_q;

    // Memory return always wins; a displaced ALU result parks in the skid entry.
    if (pop) begin
      sel_vld  = 1'b1;
      sel_addr = tag_q[head_q];
      sel_data = memData;
      if (alu_acc) begin
        skid_vld_d  = 1'b1;
        skid_addr_d = aluAddr;
        skid_data_d = aluData;
      end
    end else if (skid_vld_q) begin
      sel_vld    = 1'b1;
      sel_addr   = skid_addr_q;
      sel_data   = skid_data_q;
      skid_vld_d = 1'b0;
    end else if (alu_acc) begin
      sel_vld  = 1'b1;
      sel_addr = aluAddr;
      sel_data = aluData;
    end

    // Out-of-range destinations are consumed without touching the register file.
    we_d = sel_vld && ({1'b0, sel_addr} < NREG);
    if (sel_vld) begin
      waddr_d = sel_addr;
      wdata_d = sel_data;
    end

    if (push) begin
      tag_d[tail_q] = loadAddr;
      tail_d        = ~tail_q;
    end
    if (pop) head_d = ~head_q;
    case ({push, pop})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase

    ovf_d = ovf_q | (loadIssue && full && !pop);
    unf_d = unf_q | (memValid && (count_q == 2'd0));
  end

  always_comb begin
    for (int i = 0; i < 2; i++)
      tag_vld[i] = (count_q == 2'd2) || ((count_q == 2'd1) && (head_q == 1'(i)));
    hit1 = 1'b0;
    hit2 = 1'b0;
    for (int i = 0; i < 2; i++) begin
      hit1 = hit1 | (tag_vld[i] && (tag_q[i] == checkAddr1));
      hit2 = hit2 | (tag_vld[i] && (tag_q[i] == checkAddr2));
    end
    hit1 = (hit1 | (skid_vld_q && (skid_addr_q == checkAddr1))) && ({1'b0, checkAddr1} < NREG);
    hit2 = (hit2 | (skid_vld_q && (skid_addr_q == checkAddr2))) && ({1'b0, checkAddr2} < NREG);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tag_q       <= '0;
      head_q      <= 1'b0;
      tail_q      <= 1'b0;
      count_q     <= 2'd0;
      skid_vld_q  <= 1'b0;
      skid_addr_q <= '0;
      skid_data_q <= '0;
      we_q        <= 1'b0;
      waddr_q     <= '0;
      wdata_q     <= '0;
      ovf_q       <= 1'b0;
      unf_q       <= 1'b0;
    end else begin
      tag_q       <= tag_d;
      head_q      <= head_d;
      tail_q      <= tail_d;
      count_q     <= count_d;
      skid_vld_q  <= skid_vld_d;
      skid_addr_q <= skid_addr_d;
      skid_data_q <= skid_data_d;
      we_q        <= we_d;
      waddr_q     <= waddr_d;
      wdata_q     <= wdata_d;
      ovf_q       <= ovf_d;
      unf_q       <= unf_d;
    end
  end

  assign aluReady     = !skid_vld_q;
  assign stall        = (count_q == FULL_CNT) || hit1 || hit2;
  assign writeEnable  = we_q;
  assign writeAddr    = waddr_q;
  assign writeData    = wdata_q;
  assign loadCount    = count_q;
  assign overflowErr  = ovf_q;
  assign underflowErr = unf_q;

endmodule

// File: tb/tb_writeback_unit.sv
// Directed bench: stimulus pushes expected register writes into a scoreboard queue;
// a negedge monitor pops and compares every asserted write.
module tb_writeback_unit;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        aluValid, aluReady;
  logic [3:0]  aluAddr;
  logic [31:0] aluData;
  logic        loadIssue;
  logic [3:0]  loadAddr;
  logic        memValid;
  logic [31:0] memData;
  logic [3:0]  checkAddr1, checkAddr2;
  logic        stall, writeEnable;
  logic [3:0]  writeAddr;
  logic [31:0] writeData;
  logic [1:0]  loadCount;
  logic        overflowErr, underflowErr;

  int checks = 0;
  int failures = 0;
  logic [35:0] exp_q[$];

  writeback_unit dut (
    .clk(clk), .rst_n(rst_n),
    .aluValid(aluValid), .aluReady(aluReady), .aluAddr(aluAddr), .aluData(aluData),
    .loadIssue(loadIssue), .loadAddr(loadAddr),
    .memValid(memValid), .memData(memData),
    .checkAddr1(checkAddr1), .checkAddr2(checkAddr2), .stall(stall),
    .writeEnable(writeEnable), .writeAddr(writeAddr), .writeData(writeData),
    .loadCount(loadCount), .overflowErr(overflowErr), .underflowErr(underflowErr)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    aluValid = 0; loadIssue = 0; memValid = 0;
  endtask

  task automatic expect_wr(input logic [3:0] a, input logic [31:0] d);
    exp_q.push_back({a, d});
  endtask

  // Monitor: every asserted write must match the oldest expected write.
  always @(negedge clk) begin
    if (rst_n && writeEnable) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL wr_unexpected: got r%0d=0x%0h expected no write", writeAddr, writeData);
      end else begin
        logic [35:0] e;
        e = exp_q.pop_front();
        if ({writeAddr, writeData} !== e) begin
          failures++;
          $display("FAIL wr_data: got r%0d=0x%0h expected r%0d=0x%0h",
                   writeAddr, writeData, e[35:32], e[31:0]);
        end
      end
    end
  end

  initial begin
    rst_n = 0; idle();
    aluAddr = 0; aluData = 0; loadAddr = 0; memData = 0;
    checkAddr1 = 0; checkAddr2 = 0;
    tick(); tick();
    chk("rst_we", writeEnable, 0);
    chk("rst_waddr", writeAddr, 0);
    chk("rst_wdata", writeData, 0);
    chk("rst_cnt", loadCount, 0);
    chk("rst_ready", aluReady, 1);
    chk("rst_flags", {overflowErr, underflowErr}, 0);
    chk("rst_stall", stall, 0);
    rst_n = 1;
    tick();

    // Plain ALU write
    aluValid = 1; aluAddr = 3; aluData = 32'hDEADBEEF; expect_wr(3, 32'hDEADBEEF);
    tick(); idle();
    chk("alu_ready", aluReady, 1);

    // Two loads, full FIFO, in-order returns
    loadIssue = 1; loadAddr = 5; tick();
    loadAddr = 6; tick(); idle(); #1;
    chk("ld_cnt2", loadCount, 2);
    checkAddr1 = 6; #1;
    chk("ld_stall_full", stall, 1);
    memValid = 1; memData = 32'h11; expect_wr(5, 32'h11);
    tick(); idle(); #1;
    chk("ld_cnt1", loadCount, 1);
    chk("ld_stall_tag6", stall, 1);
    checkAddr1 = 5; #1;
    chk("ld_stall_popped5", stall, 0);
    memValid = 1; memData = 32'h22; expect_wr(6, 32'h22);
    tick(); idle(); checkAddr1 = 6; #1;
    chk("ld_cnt0", loadCount, 0);
    chk("ld_stall_clear", stall, 0);

    // Memory beats ALU; ALU result goes through skid
    loadIssue = 1; loadAddr = 4; tick(); idle();
    memValid = 1; memData = 32'hAA; aluValid = 1; aluAddr = 2; aluData = 32'hBB;
    expect_wr(4, 32'hAA); expect_wr(2, 32'hBB);
    tick(); idle(); checkAddr2 = 2; #1;
    chk("skid_ready0", aluReady, 0);
    chk("skid_stall", stall, 1);
    tick();
    chk("skid_ready1", aluReady, 1);
    chk("skid_stall_clr", stall, 0);
    checkAddr2 = 0;

    // Overflow and push+pop at full
    loadIssue = 1; loadAddr = 7; tick();
    loadAddr = 8; tick();
    loadAddr = 1; tick(); idle(); #1;
    chk("ovf_flag", overflowErr, 1);
    chk("ovf_cnt", loadCount, 2);
    loadIssue = 1; loadAddr = 3; memValid = 1; memData = 32'h77; expect_wr(7, 32'h77);
    tick(); idle(); #1;
    chk("pp_cnt", loadCount, 2);
    chk("pp_unf", underflowErr, 0);
    memValid = 1; memData = 32'h88; expect_wr(8, 32'h88);
    tick(); idle(); checkAddr1 = 1; #1;
    chk("pp_cnt1", loadCount, 1);
    chk("pp_dropped_tag", stall, 0);
    checkAddr1 = 3; #1;
    chk("pp_new_tag", stall, 1);
    memValid = 1; memData = 32'h33; expect_wr(3, 32'h33);
    tick(); idle();

    // Tag 9 never matches and never writes
    loadIssue = 1; loadAddr = 9; tick(); idle(); checkAddr1 = 9; #1;
    chk("r9_cnt", loadCount, 1);
    chk("r9_stall", stall, 0);
    memValid = 1; memData = 32'h99; tick(); idle(); #1;
    chk("r9_cnt0", loadCount, 0);

    // Underflow, out-of-range ALU writes
    memValid = 1; memData = 32'h55; tick(); idle(); #1;
    chk("unf_flag", underflowErr, 1);
    chk("unf_cnt", loadCount, 0);
    aluValid = 1; aluAddr = 9; aluData = 32'h9; tick();
    aluAddr = 12; aluData = 32'hC; tick(); idle(); tick();

    // Reset mid-operation: two loads pending, skid full
    loadIssue = 1; loadAddr = 5; tick();
    loadAddr = 6; tick();
    loadAddr = 7; memValid = 1; memData = 32'h5; aluValid = 1; aluAddr = 1; aluData = 32'h1234;
    tick(); idle(); #1;
    chk("pre_rst_we", writeEnable, 1);
    chk("pre_rst_ready", aluReady, 0);
    chk("pre_rst_cnt", loadCount, 2);
    rst_n = 0; #1;
    chk("mid_rst_we", writeEnable, 0);
    chk("mid_rst_waddr", writeAddr, 0);
    chk("mid_rst_cnt", loadCount, 0);
    chk("mid_rst_ready", aluReady, 1);
    chk("mid_rst_flags", {overflowErr, underflowErr}, 0);
    checkAddr1 = 6; #1;
    chk("mid_rst_stall", stall, 0);
    tick(); rst_n = 1; tick();
    chk("post_rst_ready", aluReady, 1);
    chk("post_rst_cnt", loadCount, 0);

    aluValid = 1; aluAddr = 8; aluData = 32'hCAFEF00D; expect_wr(8, 32'hCAFEF00D);
    tick(); idle(); tick(); tick();
    chk("sb_drained", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/writeback_unit.md
# writeback_unit

Writeback stage directly upstream of the CPU register file. Merges single-cycle ALU results and in-order, variable-latency load returns into the register file's single write port (`writeEnable`/`writeAddr`/`writeData`). Tracks outstanding load destinations in a 2-entry tag FIFO and exposes a hazard/stall signal to decode.

## Interface
- DATA_WIDTH, 32, result/data width
- ADDR_WIDTH, 4, register address width
- NUM_REGS, 9, writable registers 0..NUM_REGS-1; address 9 (PC+8 alias) and above are never written
- LQ_DEPTH, 2, outstanding-load tag FIFO depth (fixed at 2; other values unsupported)

Ports:
- clk  in  1  system clock, all state on rising edge
- rst_n  in  1  asynchronous, active-low reset
- aluValid  in  1  ALU result valid this cycle
- aluReady  out  1  unit can accept an ALU result this cycle
- aluAddr  in  4  ALU destination register
- aluData  in  32  ALU result
- loadIssue  in  1  load issued; push loadAddr into tag FIFO
- loadAddr  in  4  load destination register
- memValid  in  1  load data returning (in issue order)
- memData  in  32  load data
- checkAddr1, checkAddr2  in  4 each  decode source registers
- stall  out  1  combinational hazard/full indication to decode
- writeEnable  out  1  register file write enable (registered)
- writeAddr  out  4  register file write address (registered)
- writeData  out  32  register file write data (registered)
- loadCount  out  2  tag FIFO occupancy 0..2
- overflowErr, underflowErr  out  1 each  sticky error flags

## Operation
- Tag FIFO: 2 entries of 4-bit addresses, head/tail pointers with wrap, count 0..2.
- Push on `loadIssue` when count<2. Pop on `memValid` when count>0; `memValid` with count=0 is ignored and sets `underflowErr`.
- `loadIssue` at count=2 without a simultaneous pop is dropped and sets `overflowErr`. Push+pop in the same cycle at count=2 succeeds; count is unchanged.
- Skid buffer: 1 entry (addr, data, valid) for ALU results that lose arbitration.
- `aluReady` = !skidValid. An ALU result is accepted when `aluValid && aluReady`. `aluValid` with `aluReady`=0 is the producer's error; the unit ignores it.
- Write-port priority, one write per cycle: (1) memory return (head tag, memData); (2) skid entry; (3) newly accepted ALU result.
- An accepted ALU result that loses arbitration goes to the skid buffer.
- A skid entry that loses arbitration to memory stays in the skid buffer.
- Any selected write whose address ≥ NUM_REGS is consumed with `writeEnable`=0. It still pops or clears its source.
- `stall` = (loadCount==2) OR checkAddrN matches any valid FIFO tag OR the valid skid address, for N=1,2. Address 9 never matches.
- Error flags clear only on reset.

## Timing
- Reset (async assert, sync release): writeEnable=0, writeAddr=0, writeData=0, loadCount=0, skid empty, aluReady=1, flags=0, pointers 0.
- Latency: input in cycle N produces writeEnable/writeAddr/writeData in cycle N+1. The register file commits at the end of N+1.
- `stall` and `aluReady` are combinational from state; `stall` also depends on checkAddr.
- Back-to-back memory returns starve the skid buffer; the ALU sees aluReady=0 until a memory-free cycle.
- Reset asserted mid-operation discards FIFO tags and the skid entry; writeEnable drops to 0 immediately.

## Test plan
- Reset, then aluValid with aluAddr=3, aluData=0xDEADBEEF -> next cycle writeEnable=1, writeAddr=3, writeData=0xDEADBEEF; aluReady stays 1.
- loadIssue addr=5, then addr=6 -> loadCount=2, stall=1. checkAddr1=6 -> stall=1. memValid with data 0x11 -> write r5=0x11 and loadCount=1. memValid with data 0x22 -> write r6=0x22, loadCount=0, stall=0.
- Same cycle: memValid (tag 4, data 0xAA) and aluValid (addr 2, data 0xBB) -> cycle+1 writes r4=0xAA and aluReady=0. Cycle+2 writes r2=0xBB and aluReady returns to 1.
- At loadCount=2: loadIssue alone -> overflowErr=1, count stays 2. loadIssue together with memValid -> count stays 2, new tag is accepted, no error.
- memValid at loadCount=0 -> underflowErr=1, no write. aluValid with aluAddr=9 or 12 -> writeEnable stays 0.
- Assert rst_n=0 with 2 loads pending and skid full -> outputs go to reset values immediately; after release aluReady=1 and loadCount=0.
